// File: rtl/ysyx_22050612_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050612_seq_ctrl
// Brief    : Multi-cycle FETCH/EXEC/MEM/WB sequencer owning the NPC PC.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050612_seq_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_req,
    output logic [63:0] if_addr,
    input  logic        if_ack,
    input  logic [31:0] if_inst,
    output logic [31:0] inst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_ebreak,
    input  logic        wb_en,
    input  logic [63:0] dnpc,
    output logic [63:0] pc,
    output logic        mem_req,
    output logic        mem_wen,
    input  logic        mem_ack,
    output logic        gpr_wen,
    output logic        retire,
    output logic [63:0] instret,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [7:0]  C_TIMEOUT = 8'(TIMEOUT);
    localparam logic [31:0] C_NOP     = 32'h0000_0013;

    state_t      r_state_q, w_state_d;
    logic [63:0] r_pc_q, w_pc_d;
    logic [31:0] r_inst_q, w_inst_d;
    logic [63:0] r_instret_q, w_instret_d;
    logic [7:0]  r_wait_q, w_wait_d;
    logic        w_if_req;
    logic        w_mem_req;
    logic        w_wb;

    always_comb begin
        w_state_d   = r_state_q;
        w_pc_d      = r_pc_q;
        w_inst_d    = r_inst_q;
        w_instret_d = r_instret_q;
        w_wait_d    = r_wait_q;
        w_if_req    = 1'b0;
        w_mem_req   = 1'b0;
        w_wb        = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                w_if_req = 1'b1;
                // An ack in the timeout cycle still wins over the error.
                if (if_ack) begin
                    w_inst_d  = if_inst;
                    w_state_d = S_EXEC;
                end else if (r_wait_q == C_TIMEOUT) begin
                    w_state_d = S_ERR;
                end else begin
                    w_wait_d = r_wait_q + 8'd1;
                end
            end
            S_EXEC: begin
                w_wait_d = 8'd0;
                if (is_ebreak)               w_state_d = S_HALT;
                else if (is_load | is_store) w_state_d = S_MEM;
                else                         w_state_d = S_WB;
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_d = S_WB;
                end else if (r_wait_q == C_TIMEOUT) begin
                    w_state_d = S_ERR;
                end else begin
                    w_wait_d = r_wait_q + 8'd1;
                end
            end
            S_WB: begin
                w_wb        = 1'b1;
                w_pc_d      = dnpc;
                w_instret_d = r_instret_q + 64'd1;
                w_wait_d    = 8'd0;
                w_state_d   = S_FETCH;
            end
            S_HALT:  w_state_d = S_HALT;
            S_ERR:   w_state_d = S_ERR;
            default: w_state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q   <= S_FETCH;
            r_pc_q      <= RESET_PC;
            r_inst_q    <= C_NOP;
            r_instret_q <= 64'd0;
            r_wait_q    <= 8'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_pc_q      <= w_pc_d;
            r_inst_q    <= w_inst_d;
            r_instret_q <= w_instret_d;
            r_wait_q    <= w_wait_d;
        end
    end

    // Requests and enables are masked by reset so an abandoned access drops at once.
    assign if_req  = w_if_req & rst_n;
    assign mem_req = w_mem_req & rst_n;
    assign mem_wen = w_mem_req & is_store & rst_n;
    assign gpr_wen = w_wb & wb_en & ~is_store & rst_n;
    assign retire  = w_wb & rst_n;
    assign if_addr = r_pc_q;
    assign pc      = r_pc_q;
    assign inst    = r_inst_q;
    assign instret = r_instret_q;
    assign halt    = (r_state_q == S_HALT);
    assign err     = (r_state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050612_seq_ctrl
// Brief    : Directed plus randomized transaction-level checks of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_seq_ctrl;

    localparam logic [63:0] C_RESET_PC = 64'h8000_0000;
    localparam int          C_TIMEOUT  = 3;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ack;
    logic [31:0] if_inst;
    logic [31:0] inst;
    logic        is_load;
    logic        is_store;
    logic        is_ebreak;
    logic        wb_en;
    logic [63:0] dnpc;
    logic [63:0] pc;
    logic        mem_req;
    logic        mem_wen;
    logic        mem_ack;
    logic        gpr_wen;
    logic        retire;
    logic [63:0] instret;
    logic        halt;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Architectural view of the sequencer: what has been committed so far.
    logic [63:0] m_pc;
    logic [63:0] m_instret;
    logic [31:0] m_inst;

    ysyx_22050612_seq_ctrl #(
        .RESET_PC (C_RESET_PC),
        .TIMEOUT  (C_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_inst   (if_inst),
        .inst      (inst),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_ebreak (is_ebreak),
        .wb_en     (wb_en),
        .dnpc      (dnpc),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_ack   (mem_ack),
        .gpr_wen   (gpr_wen),
        .retire    (retire),
        .instret   (instret),
        .halt      (halt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n   = 1'b0;
        if_ack  = 1'b1;
        mem_ack = 1'b1;
        wb_en   = 1'b1;
        #2;
        chk("rst_if_req", if_req, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_gpr_wen", gpr_wen, 1'b0);
        next_cycle();
        rst_n     = 1'b1;
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        m_pc      = C_RESET_PC;
        m_instret = 64'd0;
        m_inst    = 32'h0000_0013;
        #2;
        chk("rst_pc", pc, m_pc);
        chk("rst_instret", instret, m_instret);
        chk("rst_inst", inst, m_inst);
        chk("rst_halt", halt, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_fetch", if_req, 1'b1);
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = ebreak with is_load also set.
    // Starts in the first FETCH cycle and returns in the cycle after WB (or in HALT).
    task automatic do_instr(input int kind, input int if_dly, input int mem_dly,
                            input logic wb, input logic [63:0] npc);
        logic [31:0] word;
        logic        ld;
        logic        st;
        logic        eb;
        word      = $urandom;
        ld        = (kind == 1) || (kind == 3);
        st        = (kind == 2);
        eb        = (kind == 3);
        is_load   = ld;
        is_store  = st;
        is_ebreak = eb;
        wb_en     = wb;
        dnpc      = npc;
        mem_ack   = 1'b0;
        for (int c = 0; c <= if_dly; c++) begin
            if_ack  = (c == if_dly);
            if_inst = (c == if_dly) ? word : $urandom;
            #2;
            chk("fetch_if_req", if_req, 1'b1);
            chk("fetch_if_addr", if_addr, m_pc);
            chk("fetch_mem_req", mem_req, 1'b0);
            chk("fetch_retire", retire, 1'b0);
            if (c == 0) begin
                chk("fetch_pc", pc, m_pc);
                chk("fetch_instret", instret, m_instret);
                chk("fetch_inst", inst, m_inst);
            end
            next_cycle();
        end
        if_ack  = 1'b1;
        if_inst = $urandom;
        #2;
        chk("exec_inst", inst, word);
        chk("exec_if_req", if_req, 1'b0);
        chk("exec_mem_req", mem_req, 1'b0);
        chk("exec_retire", retire, 1'b0);
        chk("exec_gpr_wen", gpr_wen, 1'b0);
        chk("exec_halt", halt, 1'b0);
        next_cycle();
        if_ack = 1'b0;
        if (eb) begin
            for (int c = 0; c < 3; c++) begin
                mem_ack = 1'b1;
                #2;
                chk("halt_flag", halt, 1'b1);
                chk("halt_mem_req", mem_req, 1'b0);
                chk("halt_if_req", if_req, 1'b0);
                chk("halt_retire", retire, 1'b0);
                chk("halt_pc", pc, m_pc);
                chk("halt_instret", instret, m_instret);
                next_cycle();
            end
            mem_ack = 1'b0;
        end else begin
            if (ld || st) begin
                for (int c = 0; c <= mem_dly; c++) begin
                    mem_ack = (c == mem_dly);
                    #2;
                    chk("mem_req", mem_req, 1'b1);
                    chk("mem_wen", mem_wen, st);
                    chk("mem_if_req", if_req, 1'b0);
                    chk("mem_retire", retire, 1'b0);
                    next_cycle();
                end
            end
            mem_ack = 1'b1;
            #2;
            chk("wb_retire", retire, 1'b1);
            chk("wb_gpr_wen", gpr_wen, wb & ~st);
            chk("wb_mem_req", mem_req, 1'b0);
            chk("wb_if_req", if_req, 1'b0);
            next_cycle();
            mem_ack   = 1'b0;
            m_pc      = npc;
            m_instret = m_instret + 64'd1;
            m_inst    = word;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        if_ack    = 1'b0;
        if_inst   = 32'd0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_ebreak = 1'b0;
        wb_en     = 1'b0;
        dnpc      = 64'd0;
        mem_ack   = 1'b0;
        m_pc      = C_RESET_PC;
        m_instret = 64'd0;
        m_inst    = 32'h0000_0013;
        next_cycle();

        // ALU instruction with immediate acks: retire in cycle 3, pc+4 in cycle 4.
        apply_reset();
        do_instr(0, 0, 0, 1'b1, C_RESET_PC + 64'd4);
        #2;
        chk("alu_pc", pc, 64'h8000_0004);
        chk("alu_instret", instret, 64'd1);

        // Load with delayed fetch and memory acks, then a store with wb_en set.
        do_instr(1, 2, 1, 1'b1, 64'h8000_0010);
        do_instr(2, 0, 2, 1'b1, 64'h8000_0014);

        // ebreak beats is_load.
        do_instr(3, 1, 0, 1'b1, 64'hdead_beef_0000_0000);

        // Fetch timeout: four request cycles, then sticky err.
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("to_if_req", if_req, 1'b1);
            chk("to_err_low", err, 1'b0);
            next_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            if_ack = 1'b1;
            #2;
            chk("to_err", err, 1'b1);
            chk("to_if_req_low", if_req, 1'b0);
            chk("to_pc", pc, C_RESET_PC);
            next_cycle();
        end
        if_ack = 1'b0;

        // Ack in the last allowed cycle is accepted.
        apply_reset();
        do_instr(0, 3, 0, 1'b0, 64'h8000_0100);
        #2;
        chk("late_ack_no_err", err, 1'b0);

        // Reset during a MEM wait; a stray ack afterwards is ignored.
        is_load   = 1'b1;
        is_store  = 1'b0;
        is_ebreak = 1'b0;
        if_ack    = 1'b1;
        if_inst   = $urandom;
        next_cycle();
        if_ack = 1'b0;
        next_cycle();
        #2;
        chk("abort_mem_req", mem_req, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        #2;
        chk("abort_mem_drop", mem_req, 1'b0);
        next_cycle();
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        #2;
        chk("abort_mem_req_low", mem_req, 1'b0);
        chk("abort_if_req", if_req, 1'b1);
        chk("abort_pc", pc, C_RESET_PC);
        chk("abort_instret", instret, 64'd0);
        next_cycle();
        mem_ack   = 1'b0;
        m_pc      = C_RESET_PC;
        m_instret = 64'd0;
        m_inst    = 32'h0000_0013;
        do_instr(0, 1, 0, 1'b1, 64'h8000_0004);

        // Randomized instruction stream.
        for (int n = 0; n < 30; n++) begin
            logic [63:0] npc;
            npc = {$urandom, $urandom};
            do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, C_TIMEOUT)),
                     int'($urandom_range(0, C_TIMEOUT)), 1'($urandom), npc);
        end
        #2;
        chk("rand_err", err, 1'b0);
        chk("rand_instret", instret, m_instret);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
